// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Holds the clear/run state enum and the default parameter values.
// Imported by the interface, the clear sequencer and the top module.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NR    = 2;
  localparam int DEF_NW    = 2;

  // CLEAR: registers are being zeroed one per cycle; RUN: normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write ports, read ports, clear request and ready.
// master = the user driving writes/reads; slave = the register file.
// Ports: clr_req, we[NW], rW[NW][AW], din[NW][WIDTH], rA[NR][AW] -> ready, r[NR][WIDTH].
interface reg_file_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NR    = DEF_NR,
  parameter int NW    = DEF_NW
);
  localparam int AW = $clog2(DEPTH);

  logic                      clr_req;
  logic                      ready;
  logic [NW-1:0]             we;
  logic [NW-1:0][AW-1:0]     rW;
  logic [NW-1:0][WIDTH-1:0]  din;
  logic [NR-1:0][AW-1:0]     rA;
  logic [NR-1:0][WIDTH-1:0]  r;

  modport master (
    output clr_req, we, rW, din, rA,
    input  ready, r
  );

  modport slave (
    input  clr_req, we, rW, din, rA,
    output ready, r
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: owns the CLEAR/RUN state and the clear index.
// Ports: clk, rst (sync, active-high), clr_req_i -> ready_o, clr_en_o, clr_addr_o.
// A clear lasts exactly DEPTH cycles; clr_req during a clear does not restart it.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req_i,
  output logic          ready_o,
  output logic          clr_en_o,
  output logic [AW-1:0] clr_addr_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // rst gates both outputs so nothing is written and reads return 0
  // while reset is held, even though the state register may still say RUN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ready_o  = 1'b0;
    clr_en_o = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en_o = !rst;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      RUN: begin
        ready_o = !rst;
        if (clr_req_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  assign clr_addr_o = idx_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NW write ports, NR combinational read ports, address 0 hardwired to 0.
// Ports: clk, rst (sync, active-high), bus (reg_file_mp_if.slave).
// Build option REGFILE_BYPASS_EN: same-cycle write-to-read forwarding (highest matching write port).
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NR    = DEF_NR,
  parameter int NW    = DEF_NW
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic          ready;
  logic          clr_en;
  logic [AW-1:0] clr_addr;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req_i  (bus.clr_req),
    .ready_o    (ready),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr)
  );

  assign bus.ready = ready;

  // Ports are applied in ascending order so the highest index wins on a
  // collision. Address 0 is never written; it is forced to 0 on read anyway.
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_addr] = '0;
    end else if (ready) begin
      for (int j = 0; j < NW; j++) begin
        if (bus.we[j] && (bus.rW[j] != '0)) begin
          mem_d[bus.rW[j]] = bus.din[j];
        end
      end
    end
  end

  // Storage has no reset: contents are only zeroed by the clear sequence.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.r = '0;
    for (int i = 0; i < NR; i++) begin
      if (ready && (bus.rA[i] != '0)) begin
        bus.r[i] = mem_q[bus.rA[i]];
`ifdef REGFILE_BYPASS_EN
        // rA is nonzero here, so a match implies a nonzero write address.
        for (int j = 0; j < NW; j++) begin
          if (bus.we[j] && (bus.rW[j] == bus.rA[i])) begin
            bus.r[i] = bus.din[j];
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: driver pushes expected read/ready values, monitor compares at negedge.
// Reference model: an array of register values plus a count of clear cycles still outstanding.
// Directed scenarios first, then randomized writes/reads/clears/resets.
module tb_reg_file_mp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;

  typedef struct {
    logic        rdy;
    logic [31:0] r0;
    logic [31:0] r1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus ();

  reg_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];
  logic last_rdy = 1'b0;

  // Reference model state.
  logic [31:0] m_reg [DEPTH];
  int          m_clr_left = DEPTH;   // cycles of clearing still to do; 0 = running
  int          m_clr_pos  = 0;       // register zeroed at the next clearing edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever a cycle's expectation is pending, compare at the negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ready", {31'b0, bus.ready}, {31'b0, e.rdy});
        chk("r0", bus.r[0], e.r0);
        chk("r1", bus.r[1], e.r1);
      end
    end
  end

  function automatic logic [31:0] model_read(input logic rdy, input logic [4:0] a,
                                             input logic [1:0] wev, input logic [4:0] w0,
                                             input logic [4:0] w1, input logic [31:0] d0,
                                             input logic [31:0] d1);
    logic [31:0] v;
    if (!rdy || a == 5'd0) return 32'd0;
    v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    if (wev[0] && w0 == a) v = d0;
    if (wev[1] && w1 == a) v = d1;
`else
    if (wev[0] && w0 == a && d0 == 32'hx) v = d0;  // never true; keeps args used
    if (wev[1] && w1 == a && d1 == 32'hx) v = d1;
`endif
    return v;
  endfunction

  // One clock cycle: drive inputs, push expectation, sample ready, take the
  // edge, then advance the model by the rules for that edge.
  task automatic cycle(input logic rs, input logic cl, input logic [1:0] wev,
                       input logic [4:0] w0, input logic [4:0] w1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [4:0] a0, input logic [4:0] a1);
    exp_t e;
    logic rdy;
    rst         = rs;
    bus.clr_req = cl;
    bus.we      = wev;
    bus.rW[0]   = w0;
    bus.rW[1]   = w1;
    bus.din[0]  = d0;
    bus.din[1]  = d1;
    bus.rA[0]   = a0;
    bus.rA[1]   = a1;
    rdy   = !rs && (m_clr_left == 0);
    e.rdy = rdy;
    e.r0  = model_read(rdy, a0, wev, w0, w1, d0, d1);
    e.r1  = model_read(rdy, a1, wev, w0, w1, d0, d1);
    exp_q.push_back(e);
    @(negedge clk);
    last_rdy = bus.ready;
    @(posedge clk);
    if (rs) begin
      m_clr_left = DEPTH;
      m_clr_pos  = 0;
    end else if (m_clr_left != 0) begin
      m_reg[m_clr_pos] = 32'd0;
      m_clr_pos++;
      m_clr_left--;
    end else begin
      if (wev[0] && w0 != 5'd0) m_reg[w0] = d0;
      if (wev[1] && w1 != 5'd0) m_reg[w1] = d1;
      if (cl) begin
        m_clr_left = DEPTH;
        m_clr_pos  = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    cycle(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, a0, a1);
  endtask

  // Counts cycles with ready low until it rises; bounded.
  task automatic count_clear(input string name);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (last_rdy) break;
      n++;
    end
    chk(name, n, 32'd32);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) m_reg[k] = 32'd0;
    rst = 1'b1;
    bus.clr_req = 1'b0;
    bus.we = '0;
    bus.rW = '0;
    bus.din = '0;
    bus.rA = '0;
    @(posedge clk);
    #1;

    // Reset for two cycles, then a full clear of exactly DEPTH cycles.
    cycle(1'b1, 1'b0, 2'b11, 5'd3, 5'd4, 32'h1, 32'h2, 5'd3, 5'd4);
    cycle(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2);
    count_clear("clear_len_after_reset");
    for (int k = 0; k < DEPTH; k += 2) idle(5'(k), 5'(k + 1));

    // Write then read from both ports.
    cycle(1'b0, 1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 5'd1, 5'd2);
    idle(5'd5, 5'd5);

    // Same-address collision: port 1 wins.
    cycle(1'b0, 1'b0, 2'b11, 5'd10, 5'd10, 32'h11111111, 32'hCAFEBABE, 5'd0, 5'd0);
    idle(5'd10, 5'd5);

    // Writes to address 0 are discarded.
    cycle(1'b0, 1'b0, 2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Same-cycle write/read of address 7 (bypass-dependent).
    cycle(1'b0, 1'b0, 2'b01, 5'd7, 5'd0, 32'h12345678, 32'd0, 5'd7, 5'd7);
    idle(5'd7, 5'd10);

    // clr_req with a same-cycle write, writes ignored during clear,
    // clr_req ignored during clear, reset ten cycles in restarts the clear.
    cycle(1'b0, 1'b1, 2'b01, 5'd12, 5'd0, 32'hA5A5A5A5, 32'd0, 5'd12, 5'd5);
    for (int k = 0; k < 10; k++)
      cycle(1'b0, (k == 4), 2'b11, 5'd20, 5'd9, $urandom, $urandom, 5'd20, 5'd5);
    cycle(1'b1, 1'b0, 2'b11, 5'd5, 5'd6, 32'h55, 32'h66, 5'd5, 5'd6);
    count_clear("clear_len_after_midclear_reset");
    idle(5'd5, 5'd12);
    idle(5'd20, 5'd9);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      logic narrow;
      narrow = ($urandom_range(0, 1) == 1);
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
            2'($urandom),
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
            $urandom, $urandom,
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
            narrow ? 5'($urandom_range(0, 7)) : 5'($urandom));
    end

    idle(5'd1, 5'd2);
    @(negedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter DEPTH, default 32, register count (power of two, >=2).
REQ-003 Parameter NR, default 2, number of read ports.
REQ-004 Parameter NW, default 2, number of write ports.
REQ-005 Derived AW = $clog2(DEPTH), address width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 clr_req  input  1  pulse to start a full register clear while running.
REQ-009 ready  output  1  high when the block accepts writes and returns stored data.
REQ-010 we  input  NW  per-port write enable.
REQ-011 rW  input  NW x AW  per-port write address, packed array.
REQ-012 din  input  NW x WIDTH  per-port write data, packed array.
REQ-013 rA  input  NR x AW  per-port read address, packed array.
REQ-014 r  output  NR x WIDTH  per-port read data, packed array.

Function
REQ-015 Block SHALL use a two-state FSM: CLEAR (sequential zeroing) and RUN.
REQ-016 In CLEAR, a clear index SHALL step 0..DEPTH-1, zeroing one register per cycle; after index DEPTH-1 the FSM SHALL enter RUN on the next edge.
REQ-017 ready SHALL be 0 in CLEAR and 1 in RUN; clear SHALL take exactly DEPTH cycles.
REQ-018 In CLEAR, all we SHALL be ignored and every r port SHALL output 0.
REQ-019 In RUN, clr_req=1 SHALL move the FSM to CLEAR with index 0 on the next edge; writes in that same cycle SHALL still commit.
REQ-020 clr_req while already in CLEAR SHALL be ignored (no restart).
REQ-021 Reads SHALL be combinational: r[i] = register rA[i], same cycle.
REQ-022 Writes SHALL commit on the rising edge when we[j]=1 and ready=1.
REQ-023 Address 0 SHALL read as 0 always; writes to address 0 SHALL be discarded.
REQ-024 Two or more ports writing the same address in one cycle: highest port index SHALL win.
REQ-025 Any number of read ports MAY read the same address; all SHALL return identical data.
REQ-026 rW/rA values >= DEPTH cannot occur (DEPTH power of two); no range checking.

Reset
REQ-027 rst=1 at an edge SHALL force CLEAR with index 0, overriding clr_req and we, including mid-clear.
REQ-028 While rst=1, ready SHALL be 0 and all r SHALL be 0.
REQ-029 Register contents SHALL NOT be cleared by rst directly; zeroing is done only by the CLEAR sequence after rst deasserts.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 Defined: in RUN, if rA[i] matches a nonzero rW[j] with we[j]=1, r[i] SHALL return that din[j] (highest matching j) in the same cycle.
REQ-032 Undefined: r[i] SHALL return the pre-write register value; new data visible from the next cycle.

Structure
REQ-033 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and default parameter constants.
REQ-034 Sub-module regfile_clr_seq SHALL own the FSM and clear index, outputting ready, clr_en, clr_addr.
REQ-035 Storage, write-priority and bypass logic SHALL reside in reg_file_mp.

Verification
REQ-036 Reset then idle: rst=1 for 2 cycles, release -> ready=0 for exactly 32 cycles, then 1; all 32 registers read 0.
REQ-037 Write port0 5<=32'hDEADBEEF, next cycle rA[0]=5 -> r[0]=32'hDEADBEEF; rA[1]=5 simultaneously -> r[1] identical.
REQ-038 Same cycle port0 10<=32'h11111111, port1 10<=32'hCAFEBABE -> reg 10 reads 32'hCAFEBABE.
REQ-039 Write 0<=32'hFFFFFFFF -> r for address 0 stays 0.
REQ-040 Write 7<=32'h12345678 with rA[0]=7 same cycle -> r[0]=32'h12345678 with REGFILE_BYPASS_EN, old value 0 without.
REQ-041 In RUN, clr_req pulse, then rst asserted 10 cycles into CLEAR -> after release, clear restarts at index 0, ready high 32 cycles later, reg 5 reads 0; writes during CLEAR ignored.
